// File: rtl/uart_rx_loader_if.sv
// rtl/uart_rx_loader_if.sv - byte-receive and memory-write signal bundle for uart_rx_loader
interface uart_rx_loader_if #(
  parameter int ADDR_W = 16
);
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              load_done;
  logic              overflow;

  // The loader masters the memory write port and consumes uart_rx strobes
  modport master (
    input  rx_done, rx_data, mem_ready,
    output mem_we, mem_addr, mem_wdata, busy, load_done, overflow
  );

  modport slave (
    output rx_done, rx_data, mem_ready,
    input  mem_we, mem_addr, mem_wdata, busy, load_done, overflow
  );
endinterface

// File: rtl/uart_rx_loader.sv
// rtl/uart_rx_loader.sv - length-prefixed UART frame loader writing payload bytes to memory
module uart_rx_loader #(
  parameter int ADDR_W    = 16,
  parameter int FIFO_LOG2 = 3
) (
  input logic             clk,
  input logic             rst,
  uart_rx_loader_if.master bus
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE
  } state_t;

  state_t            state;
  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       rx_count;
  logic              busy_q;
  logic              load_done_q;
  logic              overflow_q;

  logic [7:0]        fifo_mem [DEPTH];
  logic [FIFO_LOG2:0] wr_ptr;
  logic [FIFO_LOG2:0] rd_ptr;
  logic [ADDR_W-1:0] wr_addr;

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic payload_strobe;
  logic push;
  logic drop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_LOG2] != rd_ptr[FIFO_LOG2]) &&
                      (wr_ptr[FIFO_LOG2-1:0] == rd_ptr[FIFO_LOG2-1:0]);
  assign pop        = !fifo_empty && bus.mem_ready;

  // Strobes past the announced length are not payload; this keeps the count from overshooting N
  assign payload_strobe = bus.rx_done && (state == S_DATA) && (rx_count != len);
  assign push           = payload_strobe && (!fifo_full || pop);
  assign drop           = payload_strobe && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[FIFO_LOG2-1:0]] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      wr_addr    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        wr_addr <= wr_addr + ADDR_W'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_LEN_HI;
      len_hi      <= '0;
      len         <= '0;
      rx_count    <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      case (state)
        S_LEN_HI: begin
          if (bus.rx_done) begin
            len_hi <= bus.rx_data;
            state  <= S_LEN_LO;
            busy_q <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (bus.rx_done) begin
            len      <= {len_hi, bus.rx_data};
            rx_count <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          // Frame ends only once every counted byte has also drained to memory
          if ((rx_count == len) && fifo_empty) begin
            state       <= S_DONE;
            busy_q      <= 1'b0;
            load_done_q <= 1'b1;
          end else if (payload_strobe) begin
            rx_count <= rx_count + 16'd1;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state       <= S_LEN_HI;
          busy_q      <= 1'b0;
          load_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_we    = !fifo_empty;
  assign bus.mem_addr  = wr_addr;
  assign bus.mem_wdata = fifo_mem[rd_ptr[FIFO_LOG2-1:0]];
  assign bus.busy      = busy_q;
  assign bus.load_done = load_done_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_uart_rx_loader.sv
// tb/tb_uart_rx_loader.sv - randomized and directed bench for uart_rx_loader against a queue model
module tb_uart_rx_loader;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  uart_rx_loader_if #(.ADDR_W(16)) bus ();

  uart_rx_loader #(.ADDR_W(16), .FIFO_LOG2(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: frame progress as a byte count, FIFO as a queue of at most 8 bytes
  int          m_got;
  int          m_n;
  logic [7:0]  m_hi;
  bit          m_done;
  bit          m_ovf;
  logic [15:0] m_addr;
  logic [7:0]  mq [$];
  logic [23:0] m_log [$];
  logic [23:0] obs [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_got  = 0;
    m_n    = 0;
    m_hi   = 8'h00;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    m_addr = 16'h0000;
    mq.delete();
    m_log.delete();
  endtask

  task automatic model_edge(input bit rxd, input logic [7:0] d, input bit rdy);
    bit pop;
    bit do_push;
    pop     = (mq.size() != 0) && rdy;
    do_push = 1'b0;
    if (!m_done && m_got >= 2 && (m_got - 2) == m_n && mq.size() == 0) begin
      m_done = 1'b1;
    end else if (rxd && !m_done) begin
      if (m_got == 0) begin
        m_hi  = d;
        m_got = 1;
      end else if (m_got == 1) begin
        m_n   = {m_hi, d};
        m_got = 2;
      end else if ((m_got - 2) < m_n) begin
        if (mq.size() < 8 || pop) do_push = 1'b1;
        else m_ovf = 1'b1;
        m_got++;
      end
    end
    if (pop) begin
      m_log.push_back({m_addr, mq[0]});
      void'(mq.pop_front());
      m_addr = m_addr + 16'd1;
    end
    if (do_push) mq.push_back(d);
  endtask

  task automatic compare_all();
    check("mem_we", bus.mem_we, mq.size() != 0);
    check("mem_addr", bus.mem_addr, m_addr);
    if (mq.size() != 0) check("mem_wdata", bus.mem_wdata, mq[0]);
    check("busy", bus.busy, (m_got == 1) || (m_got >= 2 && !m_done));
    check("load_done", bus.load_done, m_done);
    check("overflow", bus.overflow, m_ovf);
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic step(input bit rxd, input logic [7:0] d, input bit rdy);
    bus.rx_done   = rxd;
    bus.rx_data   = d;
    bus.mem_ready = rdy;
    #1;
    if (bus.mem_we && bus.mem_ready) obs.push_back({bus.mem_addr, bus.mem_wdata});
    @(posedge clk);
    model_edge(rxd, d, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [7:0] d, input bit rdy, input int gap);
    step(1'b1, d, rdy);
    for (int i = 0; i < gap; i++) step(1'b0, 8'h00, rdy);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.rx_done   = 1'b0;
    bus.mem_ready = 1'b0;
    #1;
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_load_done", bus.load_done, 0);
    check("rst_overflow", bus.overflow, 0);
    model_reset();
    obs.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int c;
    c = 0;
    while (!bus.load_done && c < max_cycles) begin
      step(1'b0, 8'h00, 1'b1);
      c++;
    end
    check("drain_done", bus.load_done, 1);
  endtask

  task automatic compare_logs();
    check("wr_count", obs.size(), m_log.size());
    for (int i = 0; i < obs.size() && i < m_log.size(); i++) check("wr_entry", obs[i], m_log[i]);
  endtask

  initial begin
    logic [7:0] basic [3];
    int n;
    int pct;
    n_tests       = 0;
    n_fail        = 0;
    clk           = 1'b0;
    rst           = 1'b1;
    bus.rx_done   = 1'b0;
    bus.rx_data   = 8'h00;
    bus.mem_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Basic frame
    do_reset();
    send(8'h00, 1'b1, 2);
    send(8'h03, 1'b1, 2);
    basic = '{8'h2D, 8'h30, 8'h41};
    for (int i = 0; i < 3; i++) send(basic[i], 1'b1, 2);
    drain(10);
    check("basic_count", obs.size(), 3);
    for (int i = 0; i < 3; i++) check("basic_write", obs[i], {16'(i), basic[i]});
    check("basic_busy", bus.busy, 0);
    check("basic_ovf", bus.overflow, 0);

    // Backpressure
    do_reset();
    send(8'h00, 1'b0, 0);
    send(8'h02, 1'b0, 0);
    send(8'h2D, 1'b0, 0);
    send(8'h30, 1'b0, 0);
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 8'h00, 1'b0);
      check("bp_we", bus.mem_we, 1);
      check("bp_addr", bus.mem_addr, 0);
      check("bp_wdata", bus.mem_wdata, 8'h2D);
    end
    drain(10);
    check("bp_count", obs.size(), 2);
    check("bp_w0", obs[0], 24'h00002D);
    check("bp_w1", obs[1], 24'h000130);

    // Overflow: 10 bytes into 8 entries while memory stalls
    do_reset();
    send(8'h00, 1'b0, 0);
    send(8'h0A, 1'b0, 0);
    for (int i = 0; i < 10; i++) send(8'(i), 1'b0, 0);
    check("ovf_flag", bus.overflow, 1);
    drain(20);
    check("ovf_count", obs.size(), 8);
    for (int i = 0; i < 8; i++) check("ovf_write", obs[i], {16'(i), 8'(i)});

    // Push and pop on a full FIFO in the same cycle
    do_reset();
    send(8'h00, 1'b0, 0);
    send(8'h09, 1'b0, 0);
    for (int i = 0; i < 8; i++) send(8'(i), 1'b0, 0);
    send(8'h08, 1'b1, 0);
    check("pp_ovf", bus.overflow, 0);
    drain(20);
    check("pp_count", obs.size(), 9);
    for (int i = 0; i < 9; i++) check("pp_write", obs[i], {16'(i), 8'(i)});

    // Zero length, then DONE ignores further bytes
    do_reset();
    send(8'h00, 1'b1, 0);
    send(8'h00, 1'b1, 0);
    check("zl_not_yet", bus.load_done, 0);
    step(1'b0, 8'h00, 1'b1);
    check("zl_done", bus.load_done, 1);
    for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), 1'b1, 1);
    check("zl_no_writes", obs.size(), 0);
    check("zl_still_done", bus.load_done, 1);

    // Reset mid-payload discards buffered bytes
    do_reset();
    send(8'h00, 1'b0, 0);
    send(8'h05, 1'b0, 0);
    send(8'hAA, 1'b0, 1);
    send(8'hBB, 1'b0, 1);
    do_reset();
    send(8'h00, 1'b1, 1);
    send(8'h02, 1'b1, 1);
    send(8'h11, 1'b1, 1);
    send(8'h22, 1'b1, 1);
    drain(10);
    check("rr_count", obs.size(), 2);
    check("rr_w0", obs[0], 24'h000011);
    check("rr_w1", obs[1], 24'h000122);

    // Randomized frames with random gaps and memory stalls
    for (int f = 0; f < 25; f++) begin
      do_reset();
      n   = $urandom_range(0, 20);
      pct = $urandom_range(10, 100);
      send(8'(n >> 8), $urandom_range(1, 100) <= pct, $urandom_range(0, 2));
      send(8'(n), $urandom_range(1, 100) <= pct, $urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        send(8'($urandom_range(0, 255)), $urandom_range(1, 100) <= pct, $urandom_range(0, 2));
      end
      drain(40);
      compare_logs();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
